hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed-compare ID hazard logic of the 5-stage MIPS pipeline.
- Tracks pending register writes with per-register ready counters, so load latency is configurable rather than hard-wired.
- Adds a long-latency class for a multi-cycle mul/div unit (MDU): indefinite busy until done, with RAW and WAW stalls.
- Sits beside the ID stage and drives the IF/ID stall and EX bubble.

Parameters:
NUM_REGS, 32, architectural registers tracked (register 0 never tracked)
ADDR_W, 5, register address width, equal to clog2(NUM_REGS)
LOAD_LAT, 2, counter value loaded for a load writer (cycles until the value is forwardable to ID)
ALU_LAT, 1, counter value loaded for an ALU/immediate writer
CNT_W, 3, counter width; must hold max(LOAD_LAT, ALU_LAT)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a live instruction
id_kill  in  1  ID instruction squashed this cycle; it never issues
id_rs_addr  in  ADDR_W  rs source
id_rt_addr  in  ADDR_W  rt source
id_rs_used  in  1  rs is read
id_rt_used  in  1  rt is read
id_early  in  1  consumer resolves in ID (beq/bne/jr)
id_wr_en  in  1  instruction writes a register
id_wr_addr  in  ADDR_W  destination
id_wr_class  in  2  0=ALU, 1=LOAD, 2=LONG (MDU), 3=reserved, treated as ALU
mdu_done  in  1  MDU result written this cycle
mdu_wr_addr  in  ADDR_W  MDU destination
id_stall  out  1  hold ID
if_stall  out  1  hold PC/IF; equals id_stall
ex_flush  out  1  insert bubble into EX
issue  out  1  id_valid & ~id_kill & ~id_stall
perf_stall_cnt  out  32  stall-cycle count (optional feature)
perf_long_cnt  out  32  LONG-hazard stall count (optional feature)

Behaviour:
- Reset (rst_n=0 at edge): every cnt[r]=0, every long[r]=0, perf counters 0. With the scoreboard empty, id_stall=ex_flush=0 and issue=id_valid&~id_kill. Reset mid-operation discards all pending state; a later mdu_done is ignored.
- Source hazard, for source s (used, addr≠0):
  - Early consumer: hazard if cnt[s]≠0 or long[s].
  - Late consumer: hazard if cnt[s]>1 or long[s].
- WAW hazard: id_wr_en & wr_addr≠0 & long[wr_addr].
- Structural hazard: class LONG & any long[r] set.
- Stall output: id_stall = id_valid & ~id_kill & (any hazard), combinational. ex_flush = id_stall. if_stall = id_stall.
- Edge update, in priority order:
  1. Reset.
  2. If issue & id_wr_en & wr_addr≠0: ALU loads cnt=ALU_LAT; LOAD loads cnt=LOAD_LAT; LONG sets long=1 and cnt=0. The write overrides the decrement for that register.
  3. All other nonzero cnt decrement by 1, every cycle, independent of stall.
  4. mdu_done clears long[mdu_wr_addr]. It is ignored if the bit is clear or the address is 0.
- Simultaneous mdu_done with a dependent ID read: the stall still holds that cycle; there is no MDU bypass. Issue proceeds next cycle.
- Simultaneous mdu_done with a LONG issue to a different register: the structural hazard still stalls that cycle.
- Resulting timing: ALU→late 0 stalls; ALU→early 1; LOAD→late 1; LOAD→early 2 (for LOAD_LAT=2).
- Writes to register 0 are never recorded.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: perf_stall_cnt increments each cycle id_stall=1. perf_long_cnt increments each stall cycle in which a long-caused hazard (RAW, WAW or structural) is present. Both wrap at 2^32 and clear on reset.
- Undefined: both ports remain and are driven constant 0; no counter flops exist.

Decomposition:
- Package hazard_pkg holds:
  - class encodings CLS_ALU, CLS_LOAD, CLS_LONG
  - default latency constants
  - the counter-width rule
- Sub-module hazard_sb_entry: one register's cnt/long state and update logic, instantiated NUM_REGS-1 times via generate.
- The top level holds source muxing, hazard reduction and the perf counters.

Test Plan:
1. ALU writes r3 (issue), next cycle beq reads r3 early → id_stall=1 one cycle; addu reading r3 late → no stall.
2. lw r5 issued, next cycle addu rs=r5 → one stall cycle, ex_flush=1, then issue=1. With beq instead → two stall cycles.
3. LONG to r8, then addu reads r8 → stall held until the cycle after mdu_done (mdu_wr_addr=8); ALU writing r8 is WAW-stalled likewise; a second LONG is stalled until done.
4. lw to r0 followed by a reader of r0 → never stalls. id_kill=1 with a hazard present → id_stall=0, issue=0, no scoreboard write.
5. rst_n=0 while cnt[r5]=2 and long[r8]=1 → next cycle readers of r5/r8 do not stall; a late mdu_done for r8 has no effect.
6. With HAZARD_PERF_EN, run scenario 3 with 6 stall cycles → perf_stall_cnt=6 and perf_long_cnt=6. Without the macro, both read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: writer classes, default latencies, counter sizing.
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_LONG = 2'd2,
    CLS_RSVD = 2'd3
  } wr_class_e;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_LOAD_LAT = 2;
  localparam int DEF_ALU_LAT  = 1;
  localparam int DEF_CNT_W    = 3;

  // Minimum ready-counter width able to hold the larger of the two latencies.
  function automatic int cnt_width(input int load_lat, input int alu_lat);
    int m;
    m = (load_lat > alu_lat) ? load_lat : alu_lat;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_sb_entry.sv
// One tracked register: ready countdown for short writers plus an open-ended busy bit for MDU writers.
`default_nettype none

module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  wr_class_e        wr_class,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             long_busy
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      long_busy <= 1'b0;
    end else begin
      if (wr) begin
        case (wr_class)
          CLS_LONG: cnt <= '0;
          CLS_LOAD: cnt <= CNT_W'(LOAD_LAT);
          default:  cnt <= CNT_W'(ALU_LAT);
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      // A LONG issue to this register can only happen with the bit already clear.
      if (wr && (wr_class == CLS_LONG)) begin
        long_busy <= 1'b1;
      end else if (clr) begin
        long_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW/WAW/structural hazard scoreboard with per-register ready counters and MDU busy bits.
// Optional perf counters are enabled with the HAZARD_PERF_EN macro.
`default_nettype none

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int ALU_LAT  = DEF_ALU_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_kill,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_early,
  input  logic              id_wr_en,
  input  logic [ADDR_W-1:0] id_wr_addr,
  input  logic [1:0]        id_wr_class,
  input  logic              mdu_done,
  input  logic [ADDR_W-1:0] mdu_wr_addr,
  output logic              id_stall,
  output logic              if_stall,
  output logic              ex_flush,
  output logic              issue,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_long_cnt
);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] long_vec;
  wr_class_e           wr_class;
  logic                rs_live, rt_live, wr_live;
  logic                rs_haz, rt_haz, waw_haz, struct_haz;
  logic                long_haz, any_haz;

  assign wr_class = wr_class_e'(id_wr_class);

  // Register 0 is hardwired: never pending.
  assign cnt[0]      = '0;
  assign long_vec[0] = 1'b0;

  generate
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      logic wr_sel, clr_sel;
      assign wr_sel  = issue & id_wr_en & (id_wr_addr == ADDR_W'(r));
      assign clr_sel = mdu_done & (mdu_wr_addr == ADDR_W'(r));

      hazard_sb_entry #(
        .LOAD_LAT (LOAD_LAT),
        .ALU_LAT  (ALU_LAT),
        .CNT_W    (CNT_W)
      ) u_entry (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wr_sel),
        .wr_class  (wr_class),
        .clr       (clr_sel),
        .cnt       (cnt[r]),
        .long_busy (long_vec[r])
      );
    end
  endgenerate

  assign rs_live = id_rs_used & (id_rs_addr != '0);
  assign rt_live = id_rt_used & (id_rt_addr != '0);
  assign wr_live = id_wr_en & (id_wr_addr != '0);

  // Early consumers need the value now; late ones tolerate a final-cycle forward.
  always_comb begin
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    if (rs_live) begin
      rs_haz = long_vec[id_rs_addr] |
               (id_early ? (cnt[id_rs_addr] != '0) : (cnt[id_rs_addr] > CNT_W'(1)));
    end
    if (rt_live) begin
      rt_haz = long_vec[id_rt_addr] |
               (id_early ? (cnt[id_rt_addr] != '0) : (cnt[id_rt_addr] > CNT_W'(1)));
    end
  end

  assign waw_haz    = wr_live & long_vec[id_wr_addr];
  assign struct_haz = (wr_class == CLS_LONG) & (|long_vec);
  assign long_haz   = (rs_live & long_vec[id_rs_addr]) |
                      (rt_live & long_vec[id_rt_addr]) |
                      waw_haz | struct_haz;
  assign any_haz    = rs_haz | rt_haz | waw_haz | struct_haz;

  assign id_stall = id_valid & ~id_kill & any_haz;
  assign if_stall = id_stall;
  assign ex_flush = id_stall;
  assign issue    = id_valid & ~id_kill & ~id_stall;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] long_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      long_q  <= '0;
    end else begin
      if (id_stall) stall_q <= stall_q + 32'd1;
      if (id_stall && long_haz) long_q <= long_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_long_cnt  = long_q;
`else
  logic unused_long_haz;
  assign unused_long_haz = long_haz;
  assign perf_stall_cnt  = '0;
  assign perf_long_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic against a model.
`default_nettype none

module tb_hazard_scoreboard;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int LL = 2;
  localparam int AL = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_kill;
  logic [AW-1:0] id_rs_addr, id_rt_addr, id_wr_addr, mdu_wr_addr;
  logic          id_rs_used, id_rt_used, id_early, id_wr_en, mdu_done;
  logic [1:0]    id_wr_class;
  logic          id_stall, if_stall, ex_flush, issue;
  logic [31:0]   perf_stall_cnt, perf_long_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NUM_REGS (NR),
    .ADDR_W   (AW),
    .LOAD_LAT (LL),
    .ALU_LAT  (AL),
    .CNT_W    (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_kill        (id_kill),
    .id_rs_addr     (id_rs_addr),
    .id_rt_addr     (id_rt_addr),
    .id_rs_used     (id_rs_used),
    .id_rt_used     (id_rt_used),
    .id_early       (id_early),
    .id_wr_en       (id_wr_en),
    .id_wr_addr     (id_wr_addr),
    .id_wr_class    (id_wr_class),
    .mdu_done       (mdu_done),
    .mdu_wr_addr    (mdu_wr_addr),
    .id_stall       (id_stall),
    .if_stall       (if_stall),
    .ex_flush       (ex_flush),
    .issue          (issue),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_long_cnt  (perf_long_cnt)
  );

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  // Model: cycles until each register is ready, and MDU-pending flags.
  int          cnt_m  [NR];
  bit          long_m [NR];
  int unsigned ps_m = 0;
  int unsigned pl_m = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit src_h(input bit used, input int a, input bit early);
    if (!used || a == 0) return 1'b0;
    if (long_m[a]) return 1'b1;
    return early ? (cnt_m[a] != 0) : (cnt_m[a] > 1);
  endfunction

  function automatic bit any_long();
    for (int r = 1; r < NR; r++) if (long_m[r]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_long_h();
    bit h;
    h = 1'b0;
    if (id_rs_used && id_rs_addr != 0 && long_m[id_rs_addr]) h = 1'b1;
    if (id_rt_used && id_rt_addr != 0 && long_m[id_rt_addr]) h = 1'b1;
    if (id_wr_en && id_wr_addr != 0 && long_m[id_wr_addr]) h = 1'b1;
    if (id_wr_class == 2'd2 && any_long()) h = 1'b1;
    return h;
  endfunction

  function automatic bit exp_stall();
    bit h;
    h = src_h(id_rs_used, int'(id_rs_addr), id_early) |
        src_h(id_rt_used, int'(id_rt_addr), id_early) | exp_long_h();
    return id_valid && !id_kill && h;
  endfunction

  function automatic bit exp_issue();
    return id_valid && !id_kill && !exp_stall();
  endfunction

  // Model state advance at every rising edge.
  initial begin
    for (int r = 0; r < NR; r++) begin cnt_m[r] = 0; long_m[r] = 1'b0; end
    forever begin
      bit st, lh, iss;
      @(posedge clk);
      st  = exp_stall();
      lh  = exp_long_h();
      iss = exp_issue();
      if (!rst_n) begin
        for (int r = 0; r < NR; r++) begin cnt_m[r] = 0; long_m[r] = 1'b0; end
        ps_m = 0;
        pl_m = 0;
      end else begin
        for (int r = 1; r < NR; r++) if (cnt_m[r] > 0) cnt_m[r]--;
        if (mdu_done && mdu_wr_addr != 0) long_m[mdu_wr_addr] = 1'b0;
        if (iss && id_wr_en && id_wr_addr != 0) begin
          case (id_wr_class)
            2'd2: begin long_m[id_wr_addr] = 1'b1; cnt_m[id_wr_addr] = 0; end
            2'd1: cnt_m[id_wr_addr] = LL;
            default: cnt_m[id_wr_addr] = AL;
          endcase
        end
        if (st) ps_m++;
        if (st && lh) pl_m++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("id_stall", 32'(id_stall), 32'(exp_stall()));
        chk("if_stall", 32'(if_stall), 32'(exp_stall()));
        chk("ex_flush", 32'(ex_flush), 32'(exp_stall()));
        chk("issue",    32'(issue),    32'(exp_issue()));
`ifdef HAZARD_PERF_EN
        chk("perf_stall", perf_stall_cnt, ps_m);
        chk("perf_long",  perf_long_cnt,  pl_m);
`else
        chk("perf_stall", perf_stall_cnt, 32'd0);
        chk("perf_long",  perf_long_cnt,  32'd0);
`endif
      end
    end
  end

  task automatic idle();
    rst_n = 1'b1; id_valid = 1'b0; id_kill = 1'b0;
    id_rs_addr = '0; id_rt_addr = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    id_early = 1'b0; id_wr_en = 1'b0; id_wr_addr = '0; id_wr_class = 2'd0;
    mdu_done = 1'b0; mdu_wr_addr = '0;
  endtask

  task automatic wr_ins(input int wa, input int cls);
    idle();
    id_valid = 1'b1; id_wr_en = 1'b1; id_wr_addr = AW'(wa); id_wr_class = 2'(cls);
  endtask

  task automatic rd_ins(input int rs, input bit early);
    idle();
    id_valid = 1'b1; id_rs_used = 1'b1; id_rs_addr = AW'(rs); id_early = early;
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] p0s, p0l;

  initial begin
    idle();
    rst_n = 1'b0; id_valid = 1'b1;
    @(posedge clk); #1;
    started = 1'b1;
    #2 chk("rst_stall", 32'(id_stall), 32'd0);
    chk("rst_issue", 32'(issue), 32'd1);
    nx();

    // ALU writer then early/late readers
    wr_ins(3, 0);           #2 chk("alu_issue", 32'(issue), 32'd1); nx();
    rd_ins(3, 1'b1);        #2 chk("alu_early_stall", 32'(id_stall), 32'd1);
    chk("alu_early_flush", 32'(ex_flush), 32'd1);
    chk("alu_early_if", 32'(if_stall), 32'd1); nx();
    #2 chk("alu_early_go", 32'(issue), 32'd1); nx();
    wr_ins(3, 0); nx();
    rd_ins(3, 1'b0);        #2 chk("alu_late_nostall", 32'(id_stall), 32'd0); nx();

    // Load writer: late one stall, early two
    wr_ins(5, 1); nx();
    rd_ins(5, 1'b0);        #2 chk("ld_late_stall", 32'(ex_flush), 32'd1); nx();
    #2 chk("ld_late_go", 32'(issue), 32'd1); nx();
    wr_ins(5, 1); nx();
    rd_ins(5, 1'b1);        #2 chk("ld_early_s1", 32'(id_stall), 32'd1); nx();
    #2 chk("ld_early_s2", 32'(id_stall), 32'd1); nx();
    #2 chk("ld_early_go", 32'(issue), 32'd1); nx();

    // MDU: RAW, WAW and structural, two stall cycles each
    idle(); #2 p0s = perf_stall_cnt; p0l = perf_long_cnt; nx();
    wr_ins(8, 2); nx();
    rd_ins(8, 1'b0);        #2 chk("long_raw_s1", 32'(id_stall), 32'd1); nx();
    mdu_done = 1'b1; mdu_wr_addr = 5'd8;
    #2 chk("long_raw_done", 32'(id_stall), 32'd1); nx();
    mdu_done = 1'b0;        #2 chk("long_raw_go", 32'(issue), 32'd1); nx();
    wr_ins(8, 2); nx();
    wr_ins(8, 0);           #2 chk("long_waw_s1", 32'(id_stall), 32'd1); nx();
    mdu_done = 1'b1; mdu_wr_addr = 5'd8;
    #2 chk("long_waw_done", 32'(id_stall), 32'd1); nx();
    mdu_done = 1'b0;        #2 chk("long_waw_go", 32'(issue), 32'd1); nx();
    wr_ins(9, 2); nx();
    wr_ins(10, 2);          #2 chk("long_struct_s1", 32'(id_stall), 32'd1); nx();
    mdu_done = 1'b1; mdu_wr_addr = 5'd9;
    #2 chk("long_struct_done", 32'(id_stall), 32'd1); nx();
    mdu_done = 1'b0;        #2 chk("long_struct_go", 32'(issue), 32'd1); nx();
    idle();
`ifdef HAZARD_PERF_EN
    #2 chk("perf_stall_delta", perf_stall_cnt - p0s, 32'd6);
    chk("perf_long_delta", perf_long_cnt - p0l, 32'd6);
`else
    #2 chk("perf_stall_zero", perf_stall_cnt, 32'd0);
    chk("perf_long_zero", perf_long_cnt, 32'd0);
`endif
    nx();

    // r0 never tracked; killed instruction never writes
    wr_ins(0, 1); nx();
    rd_ins(0, 1'b1);        #2 chk("r0_nostall", 32'(id_stall), 32'd0); nx();
    wr_ins(5, 1); nx();
    rd_ins(5, 1'b0); id_kill = 1'b1; id_wr_en = 1'b1; id_wr_addr = 5'd6; id_wr_class = 2'd1;
    #2 chk("kill_stall", 32'(id_stall), 32'd0);
    chk("kill_issue", 32'(issue), 32'd0); nx();
    rd_ins(6, 1'b1);        #2 chk("kill_nowrite", 32'(id_stall), 32'd0); nx();

    // Reset mid-flight with cnt[5]=2 and long[10]=1
    wr_ins(5, 1); nx();
    idle(); rst_n = 1'b0; nx();
    idle(); id_valid = 1'b1; id_early = 1'b1;
    id_rs_used = 1'b1; id_rs_addr = 5'd5; id_rt_used = 1'b1; id_rt_addr = 5'd10;
    #2 chk("post_rst_nostall", 32'(id_stall), 32'd0); nx();
    wr_ins(11, 2); mdu_done = 1'b1; mdu_wr_addr = 5'd10;
    #2 chk("stale_done_issue", 32'(issue), 32'd1); nx();
    rd_ins(11, 1'b0);       #2 chk("stale_done_noeffect", 32'(id_stall), 32'd1); nx();
    idle(); mdu_done = 1'b1; mdu_wr_addr = 5'd11; nx();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst_n       = ($urandom_range(0, 199) != 0);
      id_valid    = ($urandom_range(0, 7) != 0);
      id_kill     = ($urandom_range(0, 9) == 0);
      id_rs_addr  = AW'($urandom_range(0, 7));
      id_rt_addr  = AW'($urandom_range(0, 7));
      id_rs_used  = 1'($urandom);
      id_rt_used  = 1'($urandom);
      id_early    = 1'($urandom);
      id_wr_en    = 1'($urandom);
      id_wr_addr  = AW'($urandom_range(0, 7));
      id_wr_class = 2'($urandom);
      mdu_done    = ($urandom_range(0, 2) == 0);
      mdu_wr_addr = AW'($urandom_range(0, 7));
      nx();
    end

    idle();
    nx();
    nx();
    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
